// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge: turns one 16-bit word request from the core into two
// sequential byte accesses on an 8-bit synchronous single-port RAM, and
// returns read data or write completion with a one-cycle ready pulse.
// Optional feature macro: MEM_BYTE_BRIDGE_RDBUF_EN adds a one-entry read
// buffer (tag, data, valid) so a repeated read of the same address completes
// one cycle after the request without touching the RAM.
module mem_byte_bridge #(
   parameter int ADDR_W     = 12,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata,
   output logic              ready,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_HI   = 3'd1,
      RD_LO   = 3'd2,
      RD_WAIT = 3'd3,
      WR_HI   = 3'd4,
      WR_LO   = 3'd5
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_lat;   // word address of the access in flight
   logic [7:0]        lo_wbyte;   // second byte to write (byte at addr+1)
   logic [7:0]        hi_rbyte;   // first byte read back (byte at addr)
   logic              hit_lat;    // current RD_WAIT pass is a buffer hit

   // "hi" is the byte at addr; endianness only decides which half of the word it is
   logic [7:0]  hi_of_wdata;
   logic [7:0]  lo_of_wdata;
   logic [15:0] rd_word;
   logic [15:0] rd_final;
   logic        buf_hit;
   logic [15:0] buf_data;

   assign hi_of_wdata = BIG_ENDIAN ? wdata[15:8] : wdata[7:0];
   assign lo_of_wdata = BIG_ENDIAN ? wdata[7:0]  : wdata[15:8];
   assign rd_word     = BIG_ENDIAN ? {hi_rbyte, ram_rdata} : {ram_rdata, hi_rbyte};
   assign rd_final    = hit_lat ? buf_data : rd_word;

`ifdef MEM_BYTE_BRIDGE_RDBUF_EN
   logic              buf_valid;
   logic [ADDR_W-1:0] buf_tag;

   assign buf_hit = buf_valid && (buf_tag == addr);

   // Read buffer: refilled by every completed read, dropped by any accepted write
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
      end else if (state == RD_WAIT) begin
         buf_valid <= 1'b1;
         buf_tag   <= addr_lat;
         buf_data  <= rd_final;
      end else if (state == IDLE && req && we) begin
         buf_valid <= 1'b0;
      end
   end
`else
   assign buf_hit  = 1'b0;
   assign buf_data = 16'h0000;
`endif

   // Main sequencer: all handshake and RAM-side outputs are registered here
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr_lat  <= '0;
         lo_wbyte  <= '0;
         hi_rbyte  <= '0;
         hit_lat   <= 1'b0;
         rdata     <= '0;
         ready     <= 1'b0;
         busy      <= 1'b0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  busy <= 1'b1;
                  if (we) begin
                     addr_lat  <= addr;
                     lo_wbyte  <= lo_of_wdata;
                     ram_addr  <= addr;
                     ram_we    <= 1'b1;
                     ram_wdata <= hi_of_wdata;
                     state     <= WR_HI;
                  end else if (buf_hit) begin
                     // Hit: skip the RAM entirely, ram_addr keeps its old value
                     addr_lat <= addr;
                     hit_lat  <= 1'b1;
                     state    <= RD_WAIT;
                  end else begin
                     addr_lat <= addr;
                     ram_addr <= addr;
                     ram_we   <= 1'b0;
                     state    <= RD_HI;
                  end
               end
            end
            RD_HI: begin
               ram_addr <= addr_lat + ADDR_W'(1);
               state    <= RD_LO;
            end
            RD_LO: begin
               hi_rbyte <= ram_rdata;
               state    <= RD_WAIT;
            end
            RD_WAIT: begin
               rdata   <= rd_final;
               ready   <= 1'b1;
               busy    <= 1'b0;
               hit_lat <= 1'b0;
               state   <= IDLE;
            end
            WR_HI: begin
               ram_addr  <= addr_lat + ADDR_W'(1);
               ram_wdata <= lo_wbyte;
               state     <= WR_LO;
            end
            WR_LO: begin
               ram_we <= 1'b0;
               ready  <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               ram_we <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Self-checking bench for mem_byte_bridge with a behavioural 8-bit
// synchronous RAM. Expected completions are queued when a request is driven
// and compared when ready is seen.
module tb_mem_byte_bridge;

   localparam bit BE = 1'b1;

   logic        clock;
   logic        reset;
   logic        req;
   logic        we;
   logic [11:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ready;
   logic        busy;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   // RAM model with a side port used only for preloading
   logic [7:0]  mem [0:4095];
   logic        pre_we;
   logic [11:0] pre_addr;
   logic [7:0]  pre_data;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit          is_read;
      logic [15:0] data;
      int          lat;
   } exp_t;
   exp_t sb[$];

   mem_byte_bridge #(.ADDR_W(12), .BIG_ENDIAN(BE)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .busy      (busy),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (ram_we)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] hi_b(input logic [15:0] w);
      return BE ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [7:0] lo_b(input logic [15:0] w);
      return BE ? w[7:0] : w[15:8];
   endfunction

   function automatic logic [15:0] word_of(input logic [7:0] h, input logic [7:0] l);
      return BE ? {h, l} : {l, h};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      @(negedge clock);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clock);
      pre_we = 1'b0;
   endtask

   // Drive one request across edge E0; returns at E0+1 with req dropped
   task automatic issue(input bit w, input logic [11:0] a, input logic [15:0] d,
                        input logic [15:0] exp_data, input int exp_lat);
      exp_t e;
      @(negedge clock);
      req = 1'b1; we = w; addr = a; wdata = d;
      e.is_read = !w; e.data = exp_data; e.lat = exp_lat;
      sb.push_back(e);
      @(posedge clock);
      #1 req = 1'b0;
   endtask

   // Wait (bounded) for ready, counting edges since E0, then score the oldest entry
   task automatic complete(input string tag, input int start_lat,
                           input bit use_forbid, input logic [11:0] forbid_a);
      int   lat;
      bit   got;
      bit   forbid_seen;
      exp_t e;
      lat = start_lat; got = 1'b0; forbid_seen = 1'b0;
      while (!got && lat < 10) begin
         @(posedge clock);
         #1;
         lat++;
         if (use_forbid && ram_addr == forbid_a) forbid_seen = 1'b1;
         if (ready) got = 1'b1;
      end
      if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_lat"}, lat, e.lat);
         if (e.is_read) check({tag, "_rdata"}, {16'h0, rdata}, {16'h0, e.data});
         check({tag, "_busy_at_ready"}, {31'h0, busy}, 32'd0);
         if (use_forbid) check({tag, "_no_foreign_access"}, {31'h0, forbid_seen}, 32'd0);
      end
   endtask

   task automatic do_read(input string tag, input logic [11:0] a,
                          input logic [15:0] exp_data, input int exp_lat);
      issue(1'b0, a, 16'h0, exp_data, exp_lat);
      check({tag, "_busy"}, {31'h0, busy}, 32'd1);
      complete(tag, 0, 1'b0, 12'h0);
   endtask

   task automatic do_write(input string tag, input logic [11:0] a, input logic [15:0] d);
      logic [11:0] a1;
      a1 = a + 12'd1;
      issue(1'b1, a, d, 16'h0, 2);
      check({tag, "_b0"}, {11'h0, ram_we, ram_addr, hi_b(d)}, {11'h0, 1'b1, a, hi_b(d)});
      @(posedge clock);
      #1;
      check({tag, "_b1"}, {11'h0, ram_we, ram_addr, ram_wdata}, {11'h0, 1'b1, a1, lo_b(d)});
      complete(tag, 1, 1'b0, 12'h0);
      check({tag, "_we_off"}, {31'h0, ram_we}, 32'd0);
   endtask

   initial begin
      exp_t e;
      logic [15:0] w;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      reset = 1'b1;
      #2 reset = 1'b0;

      preload(12'h010, 8'hAB);
      preload(12'h011, 8'hCD);
      preload(12'h031, 8'h77);
      preload(12'h050, 8'h11);
      preload(12'h051, 8'h22);
      #1;
      check("reset_outputs", {ready, busy, ram_we, ram_wdata, rdata},
            {1'b0, 1'b0, 1'b0, 8'h00, 16'h0000});
      check("reset_ram_addr", {20'h0, ram_addr}, 32'h0);
      @(negedge clock);
      reset = 1'b1;

      // Basic read
      do_read("rd_010", 12'h010, word_of(8'hAB, 8'hCD), 3);

      // Write then read back
      do_write("wr_020", 12'h020, 16'h1234);
      do_read("rb_020", 12'h020, 16'h1234, 3);

      // Address wrap
      do_write("wr_fff", 12'hFFF, 16'hBEEF);
      check("mem_fff", {24'h0, mem[12'hFFF]}, {24'h0, hi_b(16'hBEEF)});
      check("mem_000", {24'h0, mem[12'h000]}, {24'h0, lo_b(16'hBEEF)});
      do_read("rb_fff", 12'hFFF, 16'hBEEF, 3);

      // Request held while busy with a different address: ignored until ready drops
      @(negedge clock);
      req = 1'b1; we = 1'b0; addr = 12'h010;
      e.is_read = 1'b1; e.data = word_of(8'hAB, 8'hCD); e.lat = 3;
      sb.push_back(e);
      @(posedge clock);
      #1 addr = 12'h050;
      e.is_read = 1'b1; e.data = word_of(8'h11, 8'h22); e.lat = 3;
      sb.push_back(e);
      complete("hold_a", 0, 1'b1, 12'h050);
      @(posedge clock);
      #1 req = 1'b0;
      check("hold_b_accept", {20'h0, ram_addr}, 32'h050);
      complete("hold_b", 0, 1'b0, 12'h0);

      // Asynchronous reset during WR_LO
      issue(1'b1, 12'h030, 16'h5566, 16'h0, 2);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("arst_ctrl", {29'h0, ready, busy, ram_we}, 32'h0);
      check("arst_data", {ram_wdata, rdata}, 24'h0);
      check("arst_ram_addr", {20'h0, ram_addr}, 32'h0);
      if (sb.size() > 0) void'(sb.pop_front());
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      check("arst_mem_030", {24'h0, mem[12'h030]}, {24'h0, hi_b(16'h5566)});
      check("arst_mem_031", {24'h0, mem[12'h031]}, 32'h77);
      do_read("post_rst", 12'h010, word_of(8'hAB, 8'hCD), 3);

      // Repeated read: one-cycle hit when the read buffer is built in
`ifdef MEM_BYTE_BRIDGE_RDBUF_EN
      do_read("rep_010", 12'h010, word_of(8'hAB, 8'hCD), 1);
`else
      do_read("rep_010", 12'h010, word_of(8'hAB, 8'hCD), 3);
`endif
      check("rep_ram_addr", {20'h0, ram_addr}, 32'h011);

      // Write invalidates any buffered word
      w = 16'h9988;
      do_write("wr_040", 12'h040, w);
      do_read("after_wr", 12'h010, word_of(8'hAB, 8'hCD), 3);
      do_read("rb_040", 12'h040, w, 3);

      check("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
